sdram_pattern_tester: RTL and testbench
=======================================

Name: sdram_pattern_tester

Overview:
- Parametrised successor to the fixed-pattern SDRAM tester: a self-checking memory exerciser that sits in front of the SDRAM controller's request/ack port.
- On `start`, writes a selectable data pattern over a programmable inclusive address range, reads the range back and compares.
- Repeats for a configurable number of passes, inverting the pattern on odd passes.
- Reports error count, first failing address/data and completion status for bring-up and for N64 cart debug registers.

Parameters:
- DATA_WIDTH, 16, data word width of the controller port
- ADDR_WIDTH, 22, word address width
- ERR_CNT_WIDTH, 16, error counter width (saturating)
- PASSES, 2, number of write+read passes per run (>=1)
- LFSR_TAPS, 16'hB400, Galois LFSR feedback mask (DATA_WIDTH bits)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle run request; honoured only in IDLE
- mode  in  2  0=address^seed, 1=walking ones, 2=checkerboard, 3=LFSR
- seed  in  DATA_WIDTH  pattern seed for modes 0 and 3
- base_addr  in  ADDR_WIDTH  first word address (inclusive)
- end_addr  in  ADDR_WIDTH  last word address (inclusive)
- mem_req  out  1  access request; held until ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_WIDTH  access address
- mem_wdata  out  DATA_WIDTH  write data
- mem_ack  in  1  one-cycle completion; for reads, mem_rdata valid this cycle
- mem_rdata  in  DATA_WIDTH  read data
- busy  out  1  run in progress
- done  out  1  run finished; level, cleared by next accepted start
- pass_ok  out  1  done with zero errors and no cfg_error
- cfg_error  out  1  end_addr < base_addr at start
- err_count  out  ERR_CNT_WIDTH  mismatches this run, saturates at all-ones
- first_err_addr  out  ADDR_WIDTH  address of first mismatch
- first_err_data  out  DATA_WIDTH  read data at first mismatch
- pass_count  out  8  completed passes this run

Behaviour:
- Reset: all outputs 0; FSM to IDLE. Asynchronous: mem_req drops immediately, including mid-access.
- Start handling:
  - start sampled in IDLE latches mode, seed, base_addr and end_addr, and clears done, pass_ok, cfg_error, err_count, first_err_* and pass_count.
  - start while busy is ignored.
- States:
  - IDLE -> CHECK (1 cycle).
  - CHECK -> ERR if end<base; otherwise WRITE.
  - ERR: cfg_error=1, done=1, next state IDLE. done is therefore high 2 cycles after start, with no mem_req.
- WRITE:
  - mem_req=1, mem_we=1; address runs base..end.
  - On the cycle mem_ack is sampled high, the next cycle presents the next address; back-to-back is allowed.
  - After the ack at end_addr -> READ, with the address reset to base.
- READ:
  - Same sequencing with mem_we=0.
  - On ack, compare mem_rdata against the regenerated expected word.
  - On mismatch: err_count+1 (saturating); if this is the first error of the run, capture mem_addr and mem_rdata.
  - After the ack at end_addr: pass_count+1. If pass_count < PASSES -> WRITE for the next pass; else DONE.
- DONE: busy=0, done=1, pass_ok=(err_count==0), then IDLE.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable while awaiting ack. busy=1 from the cycle after start until done.
- Pattern p(a, k) for address a, pass index k (0-based):
  - mode0: zero-extend/truncate a to DATA_WIDTH, XOR seed.
  - mode1: 1 << (a mod DATA_WIDTH).
  - mode2: a[0] ? 0x55.. : 0xAA..
  - mode3: Galois LFSR; state=seed, or 1 if seed==0, at the start of every WRITE and every READ phase. The word for the current address is the current state. Advance per ack: x' = (x>>1) ^ (x[0] ? LFSR_TAPS : 0).
  - Final word = p XOR {DATA_WIDTH{k[0]}}.
- Address wrap: end_addr = all-ones terminates on compare; no wrap to 0.

Test Plan:
- Fault-free mode0: seed=0, base=0, end=7, PASSES=2, ideal memory model with 0-3 random ack wait states -> 32 accesses, pass_count=2, err_count=0, pass_ok=1; addr 3 pass1 write data 0xFFFC.
- Fault injection: model XORs 0x0008 into reads at addr 5, mode0, seed=0x1200 -> err_count=2, first_err_addr=5, first_err_data=0x120D, pass_ok=0.
- Walking ones and LFSR, both with base=16, end=17:
  - mode1 -> addr 17 writes 0x0002 on pass0 and 0xFFFD on pass1.
  - mode3 with seed=0 -> writes 0x0001 then 0xB400.
- Config error: base=10, end=9 -> cfg_error=1 and done=1 at start+2 cycles; mem_req never asserted; pass_ok=0.
- Reset mid-WRITE, asserted asynchronously between edges -> mem_req, busy and err_count are 0 before the next edge. A start pulse during busy is ignored; the run still completes normally.
- Saturation: ERR_CNT_WIDTH=4, memory stuck at 0x0000, mode0, seed=0xFFFF, range 0..31 -> err_count=15, first_err_addr=0.

Source files
------------

// File: rtl/sdram_pattern_tester.sv
// -----------------------------------------------------------------------------
// sdram_pattern_tester
//
// Self-checking memory exerciser that sits in front of the SDRAM controller's
// request/ack port. A start pulse latches the configuration. The tester then
// writes a pattern over the inclusive range base_addr..end_addr and reads the
// range back, comparing each word. This repeats for PASSES passes, and the
// pattern is inverted on odd passes. It reports the error count, the first
// failing address and data, and the completion status.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          single-cycle run request, honoured only when idle
//   mode           0=address^seed, 1=walking ones, 2=checkerboard, 3=LFSR
//   seed           pattern seed for modes 0 and 3
//   base_addr      first word address (inclusive)
//   end_addr       last word address (inclusive)
//   mem_req        access request, held until mem_ack
//   mem_we         1=write, 0=read
//   mem_addr       access address
//   mem_wdata      write data
//   mem_ack        one-cycle completion; read data valid in the same cycle
//   mem_rdata      read data
//   busy           run in progress
//   done           run finished (level, cleared by the next accepted start)
//   pass_ok        done with zero errors and no configuration error
//   cfg_error      end_addr < base_addr at start
//   err_count      saturating mismatch count for this run
//   first_err_addr address of the first mismatch
//   first_err_data read data at the first mismatch
//   pass_count     completed passes this run
// -----------------------------------------------------------------------------
module sdram_pattern_tester #(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    ADDR_WIDTH    = 22,
    parameter int                    ERR_CNT_WIDTH = 16,
    parameter int                    PASSES        = 2,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS     = 16'hB400
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [DATA_WIDTH-1:0]    seed,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [ADDR_WIDTH-1:0]    end_addr,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     pass_ok,
    output logic                     cfg_error,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic [DATA_WIDTH-1:0]    first_err_data,
    output logic [7:0]               pass_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ERR,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    // Alternating bit word; low_bit=1 gives 0x55.., low_bit=0 gives 0xAA..
    function automatic logic [DATA_WIDTH-1:0] alt_bits(input logic low_bit);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w[i] = ((i % 2) == 0) ? low_bit : ~low_bit;
        end
        return w;
    endfunction

    localparam logic [DATA_WIDTH-1:0] PAT_55 = alt_bits(1'b1);
    localparam logic [DATA_WIDTH-1:0] PAT_AA = alt_bits(1'b0);

    // Pattern word for one address. In LFSR mode the running LFSR state
    // already is the word. Odd passes invert the whole word.
    function automatic logic [DATA_WIDTH-1:0] gen_word(
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] s,
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] lf,
        input logic                  inv
    );
        logic [DATA_WIDTH-1:0] w;
        case (m)
            2'd0:    w = DATA_WIDTH'(a) ^ s;
            2'd1:    w = DATA_WIDTH'(1) << (a % ADDR_WIDTH'(DATA_WIDTH));
            2'd2:    w = a[0] ? PAT_55 : PAT_AA;
            default: w = lf;
        endcase
        return w ^ {DATA_WIDTH{inv}};
    endfunction

    state_t                  state;
    state_t                  state_next;

    logic [1:0]              cfg_mode;
    logic [DATA_WIDTH-1:0]   cfg_seed;
    logic [ADDR_WIDTH-1:0]   cfg_base;
    logic [ADDR_WIDTH-1:0]   cfg_end;
    logic [DATA_WIDTH-1:0]   lfsr;

    logic                    access_done;
    logic                    at_end;
    logic                    last_pass;
    logic                    mismatch;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic [DATA_WIDTH-1:0]   lfsr_init;
    logic [DATA_WIDTH-1:0]   lfsr_step;
    logic [DATA_WIDTH-1:0]   expected_word;

    // Shared decode for the sequencer. The end test compares addresses
    // before incrementing, so a range ending at all-ones never wraps to 0.
    always_comb begin
        access_done   = mem_req && mem_ack;
        at_end        = (mem_addr == cfg_end);
        last_pass     = ((int'(pass_count) + 1) >= PASSES);
        addr_inc      = mem_addr + ADDR_WIDTH'(1);
        lfsr_init     = (cfg_seed == '0) ? DATA_WIDTH'(1) : cfg_seed;
        lfsr_step     = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
        expected_word = gen_word(cfg_mode, cfg_seed, mem_addr, lfsr, pass_count[0]);
        mismatch      = (mem_rdata != expected_word);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = (cfg_end < cfg_base) ? ST_ERR : ST_WRITE;
            end
            ST_ERR: begin
                state_next = ST_IDLE;
            end
            ST_WRITE: begin
                if (access_done && at_end) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (access_done && at_end) begin
                    state_next = last_pass ? ST_DONE : ST_WRITE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered request port, status and result registers. Each phase
    // starts with the address at base and the LFSR reloaded, so read-back
    // regenerates exactly the sequence that was written. Status flags are
    // set on entry to ERR/DONE, so they are already valid in those states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_mode       <= '0;
            cfg_seed       <= '0;
            cfg_base       <= '0;
            cfg_end        <= '0;
            lfsr           <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_ok        <= 1'b0;
            cfg_error      <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            pass_count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_mode       <= mode;
                        cfg_seed       <= seed;
                        cfg_base       <= base_addr;
                        cfg_end        <= end_addr;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass_ok        <= 1'b0;
                        cfg_error      <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        pass_count     <= '0;
                    end
                end
                ST_CHECK: begin
                    if (cfg_end < cfg_base) begin
                        cfg_error <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= cfg_base;
                        lfsr      <= lfsr_init;
                        mem_wdata <= gen_word(cfg_mode, cfg_seed, cfg_base, lfsr_init, 1'b0);
                    end
                end
                ST_WRITE: begin
                    if (access_done) begin
                        if (at_end) begin
                            mem_we    <= 1'b0;
                            mem_addr  <= cfg_base;
                            lfsr      <= lfsr_init;
                            mem_wdata <= '0;
                        end else begin
                            mem_addr  <= addr_inc;
                            lfsr      <= lfsr_step;
                            mem_wdata <= gen_word(cfg_mode, cfg_seed, addr_inc, lfsr_step,
                                                  pass_count[0]);
                        end
                    end
                end
                ST_READ: begin
                    if (access_done) begin
                        // err_count can never return to zero within a run,
                        // so zero identifies the first mismatch.
                        if (mismatch) begin
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_CNT_WIDTH'(1);
                            end
                            if (err_count == '0) begin
                                first_err_addr <= mem_addr;
                                first_err_data <= mem_rdata;
                            end
                        end
                        if (at_end) begin
                            pass_count <= pass_count + 8'd1;
                            mem_addr   <= cfg_base;
                            lfsr       <= lfsr_init;
                            if (last_pass) begin
                                mem_req <= 1'b0;
                                mem_we  <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                pass_ok <= (err_count == '0) && !mismatch;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_wdata <= gen_word(cfg_mode, cfg_seed, cfg_base, lfsr_init,
                                                      ~pass_count[0]);
                            end
                        end else begin
                            mem_addr <= addr_inc;
                            lfsr     <= lfsr_step;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// -----------------------------------------------------------------------------
// tb_sdram_pattern_tester
//
// Directed bench for sdram_pattern_tester. A memory responder with random
// 0-3 cycle wait states also checks every requested access against an
// expected access list. The list is built from the pattern rules, using
// plain arithmetic, before each run. Final status is checked against the
// model and against hand-computed values. A second instance with a 4-bit
// error counter checks saturation against a memory stuck at zero.
// -----------------------------------------------------------------------------
module tb_sdram_pattern_tester;

    localparam int PASSES = 2;

    typedef struct {
        logic        we;
        int          addr;
        logic [15:0] data;
        int          k;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic [21:0] base_addr;
    logic [21:0] end_addr;
    logic        mem_req;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        pass_ok;
    logic        cfg_error;
    logic [15:0] err_count;
    logic [21:0] first_err_addr;
    logic [15:0] first_err_data;
    logic [7:0]  pass_count;

    logic        start_s;
    logic        mem_req_s;
    logic        mem_we_s;
    logic [21:0] mem_addr_s;
    logic [15:0] mem_wdata_s;
    logic        mem_ack_s;
    logic [15:0] mem_rdata_s;
    logic        busy_s;
    logic        done_s;
    logic        pass_ok_s;
    logic        cfg_error_s;
    logic [3:0]  err_count_s;
    logic [21:0] first_err_addr_s;
    logic [15:0] first_err_data_s;
    logic [7:0]  pass_count_s;

    int          errors = 0;
    int          checks = 0;

    acc_t        exp_q[$];
    bit          model_active = 1'b0;
    bit          fault_en = 1'b0;
    int          fault_addr = 0;
    int          ack_total = 0;
    logic [15:0] mem_array [0:63];
    logic [15:0] seen_w [0:127];
    bit          fresh = 1'b1;
    int          wait_left = 0;

    always #5 clk = ~clk;

    sdram_pattern_tester #(
        .DATA_WIDTH(16), .ADDR_WIDTH(22), .ERR_CNT_WIDTH(16), .PASSES(PASSES),
        .LFSR_TAPS(16'hB400)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .base_addr(base_addr), .end_addr(end_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass_ok(pass_ok), .cfg_error(cfg_error),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .pass_count(pass_count)
    );

    sdram_pattern_tester #(
        .DATA_WIDTH(16), .ADDR_WIDTH(22), .ERR_CNT_WIDTH(4), .PASSES(PASSES),
        .LFSR_TAPS(16'hB400)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start_s), .mode(mode), .seed(seed),
        .base_addr(base_addr), .end_addr(end_addr),
        .mem_req(mem_req_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .mem_ack(mem_ack_s), .mem_rdata(mem_rdata_s),
        .busy(busy_s), .done(done_s), .pass_ok(pass_ok_s), .cfg_error(cfg_error_s),
        .err_count(err_count_s), .first_err_addr(first_err_addr_s),
        .first_err_data(first_err_data_s), .pass_count(pass_count_s)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] model_lfsr(input logic [15:0] s, input int steps);
        logic [15:0] x;
        x = (s == 16'h0) ? 16'h0001 : s;
        for (int i = 0; i < steps; i++) begin
            x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
        end
        return x;
    endfunction

    function automatic logic [15:0] model_word(input logic [1:0] m, input logic [15:0] s,
                                               input int a, input int b, input int k);
        logic [15:0] w;
        logic [31:0] av;
        av = a;
        case (m)
            2'd0:    w = av[15:0] ^ s;
            2'd1:    w = 16'h0001 << (a % 16);
            2'd2:    w = ((a % 2) == 1) ? 16'h5555 : 16'hAAAA;
            default: w = model_lfsr(s, a - b);
        endcase
        if ((k % 2) == 1) begin
            w = ~w;
        end
        return w;
    endfunction

    // Memory responder plus the per-cycle access checker for the main DUT.
    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ack = 1'b0;
            fresh   = 1'b1;
        end else begin
            if (model_active) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected access", 32'd1, 32'd0);
                end else begin
                    checkOutput("access we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
                    checkOutput("access addr", {10'd0, mem_addr}, exp_q[0].addr);
                    if (exp_q[0].we) begin
                        checkOutput("write data", {16'd0, mem_wdata}, {16'd0, exp_q[0].data});
                    end
                end
            end
            if (fresh) begin
                wait_left = $urandom_range(0, 3);
                fresh     = 1'b0;
            end
            if (wait_left == 0) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_array[mem_addr[5:0]] = mem_wdata;
                end else begin
                    mem_rdata = mem_array[mem_addr[5:0]] ^
                                ((fault_en && int'(mem_addr) == fault_addr) ? 16'h0008 : 16'h0000);
                end
                if (model_active && exp_q.size() > 0) begin
                    if (exp_q[0].we) begin
                        seen_w[exp_q[0].k * 64 + int'(mem_addr[5:0])] = mem_wdata;
                    end
                    void'(exp_q.pop_front());
                    ack_total++;
                end
                fresh = 1'b1;
            end else begin
                mem_ack = 1'b0;
                wait_left--;
            end
        end
    end

    // Zero-wait responder for the saturation instance; its memory reads back 0.
    always @(negedge clk) begin
        mem_ack_s = mem_req_s;
    end

    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] s, input int b,
                                 input int e, input bit fault, input int faddr, input bit poke);
        int          exp_err;
        int          exp_first_addr;
        logic [15:0] exp_first_data;
        logic [15:0] w;
        logic [15:0] ret;
        exp_q.delete();
        exp_err        = 0;
        exp_first_addr = 0;
        exp_first_data = 16'h0;
        for (int k = 0; k < PASSES; k++) begin
            for (int a = b; a <= e; a++) begin
                exp_q.push_back('{1'b1, a, model_word(m, s, a, b, k), k});
            end
            for (int a = b; a <= e; a++) begin
                w   = model_word(m, s, a, b, k);
                ret = w ^ ((fault && a == faddr) ? 16'h0008 : 16'h0000);
                exp_q.push_back('{1'b0, a, w, k});
                if (ret != w) begin
                    if (exp_err == 0) begin
                        exp_first_addr = a;
                        exp_first_data = ret;
                    end
                    exp_err++;
                end
            end
        end
        for (int i = 0; i < 128; i++) begin
            seen_w[i] = 16'h0;
        end
        ack_total  = 0;
        fault_en   = fault;
        fault_addr = faddr;
        mode       = m;
        seed       = s;
        base_addr  = 22'(b);
        end_addr   = 22'(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        model_active = 1'b1;
        checkOutput("busy after start", {31'd0, busy}, 32'd1);
        checkOutput("done cleared by start", {31'd0, done}, 32'd0);
        if (poke) begin
            repeat (4) @(negedge clk);
            mode      = ~m;
            base_addr = 22'd3;
            end_addr  = 22'd1;
            start     = 1'b1;
            @(negedge clk) start = 1'b0;
            mode      = m;
            base_addr = 22'(b);
            end_addr  = 22'(e);
            checkOutput("busy after ignored start", {31'd0, busy}, 32'd1);
        end
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
        end
        model_active = 1'b0;
        checkOutput("done reached", {31'd0, done}, 32'd1);
        checkOutput("busy at end", {31'd0, busy}, 32'd0);
        checkOutput("accesses left", exp_q.size(), 32'd0);
        checkOutput("access total", ack_total, 4 * (e - b + 1));
        checkOutput("cfg_error", {31'd0, cfg_error}, 32'd0);
        checkOutput("pass_count", {24'd0, pass_count}, PASSES);
        checkOutput("err_count", {16'd0, err_count}, exp_err);
        checkOutput("first_err_addr", {10'd0, first_err_addr}, exp_first_addr);
        checkOutput("first_err_data", {16'd0, first_err_data}, {16'd0, exp_first_data});
        checkOutput("pass_ok", {31'd0, pass_ok}, (exp_err == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_sat;
        reset       = 1'b1;
        start       = 1'b0;
        start_s     = 1'b0;
        mode        = 2'd0;
        seed        = 16'h0;
        base_addr   = 22'd0;
        end_addr    = 22'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0;
        mem_rdata_s = 16'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset err_count", {16'd0, err_count}, 32'd0);
        checkOutput("reset pass_count", {24'd0, pass_count}, 32'd0);
        checkOutput("reset mem_addr", {10'd0, mem_addr}, 32'd0);
        reset = 1'b0;

        $display("[TB] fault-free mode0 run");
        applyStimulus(2'd0, 16'h0000, 0, 7, 1'b0, 0, 1'b0);
        checkOutput("run1 accesses", ack_total, 32'd32);
        checkOutput("run1 pass_ok", {31'd0, pass_ok}, 32'd1);
        checkOutput("run1 addr3 pass1 data", {16'd0, seen_w[64 + 3]}, 32'h0000FFFC);

        $display("[TB] fault injection at address 5");
        applyStimulus(2'd0, 16'h1200, 0, 7, 1'b1, 5, 1'b0);
        checkOutput("fault err_count", {16'd0, err_count}, 32'd2);
        checkOutput("fault first addr", {10'd0, first_err_addr}, 32'd5);
        checkOutput("fault first data", {16'd0, first_err_data}, 32'h0000120D);
        checkOutput("fault pass_ok", {31'd0, pass_ok}, 32'd0);

        $display("[TB] walking ones 16..17");
        applyStimulus(2'd1, 16'h0000, 16, 17, 1'b0, 0, 1'b0);
        checkOutput("walk addr17 pass0", {16'd0, seen_w[17]}, 32'h00000002);
        checkOutput("walk addr17 pass1", {16'd0, seen_w[64 + 17]}, 32'h0000FFFD);

        $display("[TB] LFSR 16..17 seed 0");
        applyStimulus(2'd3, 16'h0000, 16, 17, 1'b0, 0, 1'b0);
        checkOutput("lfsr addr16 pass0", {16'd0, seen_w[16]}, 32'h00000001);
        checkOutput("lfsr addr17 pass0", {16'd0, seen_w[17]}, 32'h0000B400);

        $display("[TB] checkerboard and LFSR with seed");
        applyStimulus(2'd2, 16'h0000, 2, 6, 1'b0, 0, 1'b0);
        checkOutput("checker addr3 pass0", {16'd0, seen_w[3]}, 32'h00005555);
        applyStimulus(2'd3, 16'hACE1, 8, 13, 1'b1, 10, 1'b0);

        $display("[TB] configuration error");
        base_addr = 22'd10;
        end_addr  = 22'd9;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checkOutput("cfg +1 done", {31'd0, done}, 32'd0);
        checkOutput("cfg +1 busy", {31'd0, busy}, 32'd1);
        checkOutput("cfg +1 mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        checkOutput("cfg +2 done", {31'd0, done}, 32'd1);
        checkOutput("cfg +2 cfg_error", {31'd0, cfg_error}, 32'd1);
        checkOutput("cfg +2 pass_ok", {31'd0, pass_ok}, 32'd0);
        checkOutput("cfg +2 busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("cfg no mem_req", {31'd0, mem_req}, 32'd0);
        end

        $display("[TB] asynchronous reset mid-write");
        mode      = 2'd0;
        seed      = 16'h0000;
        base_addr = 22'd0;
        end_addr  = 22'd7;
        fault_en  = 1'b0;
        exp_q.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        checkOutput("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("pre-reset mem_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async reset mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("async reset busy", {31'd0, busy}, 32'd0);
        checkOutput("async reset err_count", {16'd0, err_count}, 32'd0);
        @(negedge clk) reset = 1'b0;

        $display("[TB] run with ignored start while busy");
        applyStimulus(2'd0, 16'h00A5, 0, 7, 1'b0, 0, 1'b1);
        checkOutput("poke run accesses", ack_total, 32'd32);
        checkOutput("poke run pass_ok", {31'd0, pass_ok}, 32'd1);

        $display("[TB] error counter saturation");
        mode      = 2'd0;
        seed      = 16'hFFFF;
        base_addr = 22'd0;
        end_addr  = 22'd31;
        exp_sat   = 0;
        for (int k = 0; k < PASSES; k++) begin
            for (int a = 0; a <= 31; a++) begin
                if (model_word(2'd0, 16'hFFFF, a, 0, k) != 16'h0000) begin
                    exp_sat++;
                end
            end
        end
        if (exp_sat > 15) begin
            exp_sat = 15;
        end
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        for (int i = 0; i < 1000 && !done_s; i++) begin
            @(negedge clk);
        end
        checkOutput("sat done", {31'd0, done_s}, 32'd1);
        checkOutput("sat err_count model", {28'd0, err_count_s}, exp_sat);
        checkOutput("sat err_count", {28'd0, err_count_s}, 32'd15);
        checkOutput("sat first addr", {10'd0, first_err_addr_s}, 32'd0);
        checkOutput("sat first data", {16'd0, first_err_data_s}, 32'd0);
        checkOutput("sat pass_ok", {31'd0, pass_ok_s}, 32'd0);
        checkOutput("sat pass_count", {24'd0, pass_count_s}, PASSES);
        checkOutput("sat cfg_error", {31'd0, cfg_error_s}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
